// File: rtl/xalu_seq_ctrl_pkg.sv
// rtl/xalu_seq_ctrl_pkg.sv - op codes, FSM encoding and op-class helpers for the XALU sequencer
package xalu_seq_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

  function automatic logic is_move(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic writes_gpr(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/xalu_seq_ctrl_if.sv
// rtl/xalu_seq_ctrl_if.sv - EX/XALU side signal bundle of the sequencer
interface xalu_seq_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        hilo_read;
  logic        Intreq;
  logic        xalu_start;
  logic [2:0]  xalu_op;
  logic [31:0] xalu_a;
  logic [31:0] xalu_b;
  logic [1:0]  xalu_we;
  logic        xalu_busy;
  logic [31:0] xalu_lo;
  logic        stall;
  logic        mul_wb_valid;
  logic [31:0] mul_wb_data;
  logic        timeout_err;

  modport slave (
    input  op_valid, op_code, op_a, op_b, hilo_read, Intreq, xalu_busy, xalu_lo,
    output op_ready, xalu_start, xalu_op, xalu_a, xalu_b, xalu_we, stall,
           mul_wb_valid, mul_wb_data, timeout_err
  );

  modport master (
    output op_valid, op_code, op_a, op_b, hilo_read, Intreq, xalu_busy, xalu_lo,
    input  op_ready, xalu_start, xalu_op, xalu_a, xalu_b, xalu_we, stall,
           mul_wb_valid, mul_wb_data, timeout_err
  );
endinterface

// File: rtl/xalu_seq_ctrl_timer.sv
// rtl/xalu_seq_ctrl_timer.sv - guard counter and optional busy-wait timeout (XALU_SEQ_TIMEOUT_EN)
module xalu_seq_timer #(
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic wait_i,
  input  logic busy_i,
  output logic guard_zero_o,
  output logic expire_o
);

  localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  logic [GW-1:0] guard_q, guard_d;

  always_comb begin
    guard_d = guard_q;
    if (load_i) begin
      guard_d = GW'(GUARD_CYCLES);
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      guard_q <= '0;
    end else begin
      guard_q <= guard_d;
    end
  end

  assign guard_zero_o = (guard_q == '0);

`ifdef XALU_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counts WAIT cycles already elapsed; fires on the WAIT cycle numbered TIMEOUT_CYCLES.
  always_comb begin
    tcnt_d = '0;
    if (wait_i) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign expire_o = wait_i && busy_i && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{wait_i, busy_i, (TIMEOUT_CYCLES > 0)};
  assign expire_o = 1'b0;
`endif

endmodule

// File: rtl/xalu_seq_ctrl.sv
// rtl/xalu_seq_ctrl.sv - XALU issue sequencer: launch, completion tracking, stall, mul write-back (XALU_SEQ_TIMEOUT_EN)
module xalu_seq_ctrl
  import xalu_seq_ctrl_pkg::*;
#(
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           Clk,
  input logic           Clr,
  xalu_seq_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        start_q;
  logic [1:0]  we_q, we_d;
  logic        mul_wb_valid_q;
  logic [31:0] mul_wb_data_q;
  logic        take, launch, mul_done;
  logic        guard_zero, expire;

  xalu_seq_timer #(
    .GUARD_CYCLES  (GUARD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i       (Clk),
    .rst_i       (Clr),
    .load_i      (launch),
    .wait_i      (state_q == ST_WAIT),
    .busy_i      (bus.xalu_busy),
    .guard_zero_o(guard_zero),
    .expire_o    (expire)
  );

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    launch   = 1'b0;
    we_d     = 2'b00;
    mul_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Squashed ops are acknowledged but leave no trace.
        if (bus.op_valid && !bus.Intreq) begin
          if (is_arith(bus.op_code)) begin
            take    = 1'b1;
            launch  = 1'b1;
            state_d = ST_LAUNCH;
          end else if (is_move(bus.op_code)) begin
            take = 1'b1;
            we_d = {bus.op_code == OP_MTHI, bus.op_code == OP_MTLO};
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (expire || (guard_zero && !bus.xalu_busy)) begin
          state_d  = ST_DONE;
          mul_done = writes_gpr(op_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      start_q        <= 1'b0;
      we_q           <= 2'b00;
      mul_wb_valid_q <= 1'b0;
      mul_wb_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      start_q        <= launch;
      we_q           <= we_d;
      mul_wb_valid_q <= mul_done;
      if (take) begin
        op_q <= bus.op_code;
        a_q  <= bus.op_a;
        b_q  <= bus.op_b;
      end
      if (mul_done) begin
        mul_wb_data_q <= bus.xalu_lo;
      end
    end
  end

`ifdef XALU_SEQ_TIMEOUT_EN
  logic timeout_err_q;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      timeout_err_q <= 1'b0;
    end else if (expire) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.op_ready     = (state_q == ST_IDLE) && bus.op_valid && !Clr;
  assign bus.stall        = (state_q != ST_IDLE) && (bus.op_valid || bus.hilo_read);
  assign bus.xalu_start   = start_q;
  assign bus.xalu_op      = op_q;
  assign bus.xalu_a       = a_q;
  assign bus.xalu_b       = b_q;
  assign bus.xalu_we      = we_q;
  assign bus.mul_wb_valid = mul_wb_valid_q;
  assign bus.mul_wb_data  = mul_wb_data_q;

endmodule

// File: tb/tb_xalu_seq_ctrl.sv
// tb/tb_xalu_seq_ctrl.sv - directed self-checking bench for xalu_seq_ctrl (XALU_SEQ_TIMEOUT_EN adds a timeout scenario)
module tb_xalu_seq_ctrl;
  import xalu_seq_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Clr;
  int   n_vec = 0;
  int   n_err = 0;

  xalu_seq_ctrl_if bus ();

  xalu_seq_ctrl #(
    .GUARD_CYCLES  (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    bus.op_valid = 1'b1; bus.op_code = OP_DIV; bus.op_a = 32'h11; bus.op_b = 32'h22;
    bus.hilo_read = 1'b0; bus.Intreq = 1'b0; bus.xalu_busy = 1'b0; bus.xalu_lo = '0;
    next_cycle();
    next_cycle();
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL reset_op_ready got %b exp 0", bus.op_ready); end
    next_cycle();
    Clr = 1'b0; bus.op_valid = 1'b0; bus.hilo_read = 1'b1;
    @(negedge Clk);
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    n_vec++; if (bus.xalu_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b exp 0", bus.xalu_start); end
    n_vec++; if (bus.xalu_we !== 2'b00) begin n_err++; $display("FAIL reset_we got %b exp 00", bus.xalu_we); end
    n_vec++; if (bus.mul_wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b exp 0", bus.mul_wb_valid); end
    n_vec++; if (bus.xalu_op !== 3'd0) begin n_err++; $display("FAIL reset_op got %0d exp 0", bus.xalu_op); end
    n_vec++; if (bus.xalu_a !== 32'd0) begin n_err++; $display("FAIL reset_a got %h exp 0", bus.xalu_a); end
    n_vec++; if (bus.xalu_b !== 32'd0) begin n_err++; $display("FAIL reset_b got %h exp 0", bus.xalu_b); end
    n_vec++; if (bus.mul_wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h exp 0", bus.mul_wb_data); end
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b exp 0", bus.timeout_err); end
    next_cycle();
    bus.hilo_read = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.xalu_start !== 1'b0) begin n_err++; $display("FAIL reset_no_launch got %b exp 0", bus.xalu_start); end
  endtask

  task automatic test_mult_long();
    logic exp;
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd2;
    bus.hilo_read = 1'b0; bus.xalu_busy = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL mult_accept got %b exp 1", bus.op_ready); end
    for (int k = 1; k <= 37; k++) begin
      next_cycle();
      bus.op_valid = (k == 35 || k == 36); bus.op_code = OP_NOP; bus.op_a = 32'h5;
      bus.hilo_read = (k <= 36); bus.xalu_busy = (k >= 2 && k <= 33);
      @(negedge Clk);
      exp = (k == 1);
      n_vec++; if (bus.xalu_start !== exp) begin n_err++; $display("FAIL mult_start k=%0d got %b exp %b", k, bus.xalu_start, exp); end
      n_vec++; if (bus.mul_wb_valid !== 1'b0) begin n_err++; $display("FAIL mult_wb_valid k=%0d got %b exp 0", k, bus.mul_wb_valid); end
      if (k <= 36) begin
        exp = (k <= 35);
        n_vec++; if (bus.stall !== exp) begin n_err++; $display("FAIL mult_stall k=%0d got %b exp %b", k, bus.stall, exp); end
      end
      if (k == 35 || k == 36) begin
        exp = (k == 36);
        n_vec++; if (bus.op_ready !== exp) begin n_err++; $display("FAIL mult_ready k=%0d got %b exp %b", k, bus.op_ready, exp); end
      end
      if (k == 1) begin
        n_vec++; if (bus.xalu_op !== OP_MULT) begin n_err++; $display("FAIL mult_op got %0d exp 0", bus.xalu_op); end
        n_vec++; if (bus.xalu_b !== 32'd2) begin n_err++; $display("FAIL mult_b got %h exp 2", bus.xalu_b); end
      end
      if (k == 1 || k == 37) begin
        n_vec++; if (bus.xalu_a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_a k=%0d got %h exp ffffffff", k, bus.xalu_a); end
      end
      if (k == 37) begin
        n_vec++; if (bus.xalu_we !== 2'b00) begin n_err++; $display("FAIL nop_we got %b exp 00", bus.xalu_we); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_MUL; bus.op_a = 32'd7; bus.op_b = 32'd6;
    bus.hilo_read = 1'b0; bus.xalu_busy = 1'b0; bus.xalu_lo = 32'd42;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL mul_accept got %b exp 1", bus.op_ready); end
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      bus.op_valid = (k == 3 || k == 4); bus.op_code = OP_MULTU; bus.op_a = 32'd1; bus.op_b = 32'd1;
      bus.hilo_read = (k == 8); bus.xalu_lo = (k <= 2) ? 32'd42 : 32'd0;
      @(negedge Clk);
      exp = (k == 1 || k == 5);
      n_vec++; if (bus.xalu_start !== exp) begin n_err++; $display("FAIL b2b_start k=%0d got %b exp %b", k, bus.xalu_start, exp); end
      exp = (k == 3);
      n_vec++; if (bus.mul_wb_valid !== exp) begin n_err++; $display("FAIL mul_wb_valid k=%0d got %b exp %b", k, bus.mul_wb_valid, exp); end
      if (k == 3 || k == 7) begin
        n_vec++; if (bus.mul_wb_data !== 32'd42) begin n_err++; $display("FAIL mul_wb_data k=%0d got %0d exp 42", k, bus.mul_wb_data); end
      end
      if (k == 3 || k == 4) begin
        exp = (k == 4);
        n_vec++; if (bus.op_ready !== exp) begin n_err++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, bus.op_ready, exp); end
        exp = (k == 3);
        n_vec++; if (bus.stall !== exp) begin n_err++; $display("FAIL b2b_stall k=%0d got %b exp %b", k, bus.stall, exp); end
      end
      if (k == 5) begin
        n_vec++; if (bus.xalu_op !== OP_MULTU) begin n_err++; $display("FAIL b2b_op got %0d exp 1", bus.xalu_op); end
        n_vec++; if (bus.xalu_a !== 32'd1) begin n_err++; $display("FAIL b2b_a got %h exp 1", bus.xalu_a); end
      end
      if (k == 8) begin
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL b2b_idle_stall got %b exp 0", bus.stall); end
      end
    end
  endtask

  task automatic test_intreq();
    logic exp;
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_DIV; bus.op_a = 32'hDEAD; bus.op_b = 32'd3;
    bus.Intreq = 1'b1; bus.hilo_read = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL squash_ready got %b exp 1", bus.op_ready); end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      bus.op_valid = 1'b0; bus.Intreq = 1'b0; bus.hilo_read = 1'b1;
      @(negedge Clk);
      n_vec++; if (bus.xalu_start !== 1'b0) begin n_err++; $display("FAIL squash_start k=%0d got %b exp 0", k, bus.xalu_start); end
      n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL squash_stall k=%0d got %b exp 0", k, bus.stall); end
      if (k == 1) begin
        n_vec++; if (bus.xalu_a !== 32'd1) begin n_err++; $display("FAIL squash_a got %h exp 1", bus.xalu_a); end
      end
    end
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.hilo_read = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL late_int_accept got %b exp 1", bus.op_ready); end
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      bus.op_valid = 1'b0; bus.Intreq = (j == 1); bus.hilo_read = 1'b1;
      @(negedge Clk);
      exp = (j == 1);
      n_vec++; if (bus.xalu_start !== exp) begin n_err++; $display("FAIL late_int_start j=%0d got %b exp %b", j, bus.xalu_start, exp); end
      exp = (j <= 3);
      n_vec++; if (bus.stall !== exp) begin n_err++; $display("FAIL late_int_stall j=%0d got %b exp %b", j, bus.stall, exp); end
    end
    bus.Intreq = 1'b0;
  endtask

  task automatic test_moves();
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_MTHI; bus.op_a = 32'h1234; bus.hilo_read = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL mthi_ready got %b exp 1", bus.op_ready); end
    next_cycle();
    bus.op_code = OP_MTLO; bus.op_a = 32'h55AA;
    @(negedge Clk);
    n_vec++; if (bus.xalu_we !== 2'b10) begin n_err++; $display("FAIL mthi_we got %b exp 10", bus.xalu_we); end
    n_vec++; if (bus.xalu_a !== 32'h1234) begin n_err++; $display("FAIL mthi_a got %h exp 1234", bus.xalu_a); end
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL mtlo_ready got %b exp 1", bus.op_ready); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mthi_stall got %b exp 0", bus.stall); end
    n_vec++; if (bus.xalu_start !== 1'b0) begin n_err++; $display("FAIL mthi_start got %b exp 0", bus.xalu_start); end
    next_cycle();
    bus.op_valid = 1'b0; bus.hilo_read = 1'b1;
    @(negedge Clk);
    n_vec++; if (bus.xalu_we !== 2'b01) begin n_err++; $display("FAIL mtlo_we got %b exp 01", bus.xalu_we); end
    n_vec++; if (bus.xalu_a !== 32'h55AA) begin n_err++; $display("FAIL mtlo_a got %h exp 55aa", bus.xalu_a); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mtlo_stall got %b exp 0", bus.stall); end
    next_cycle();
    bus.hilo_read = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.xalu_we !== 2'b00) begin n_err++; $display("FAIL move_we_clear got %b exp 00", bus.xalu_we); end
  endtask

  task automatic test_clr_wait();
    logic exp;
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_MUL; bus.op_a = 32'd3; bus.op_b = 32'd3;
    bus.xalu_lo = 32'd99; bus.hilo_read = 1'b1; bus.xalu_busy = 1'b0;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL clr_accept got %b exp 1", bus.op_ready); end
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      Clr = (k == 3); bus.xalu_busy = (k == 2 || k == 3);
      bus.op_valid = (k == 4); bus.op_code = OP_DIVU; bus.op_a = 32'd9; bus.op_b = 32'd3;
      @(negedge Clk);
      n_vec++; if (bus.mul_wb_valid !== 1'b0) begin n_err++; $display("FAIL clr_wb_valid k=%0d got %b exp 0", k, bus.mul_wb_valid); end
      exp = (k == 1 || k == 5);
      n_vec++; if (bus.xalu_start !== exp) begin n_err++; $display("FAIL clr_start k=%0d got %b exp %b", k, bus.xalu_start, exp); end
      if (k != 3) begin
        exp = (k <= 2) || (k >= 5 && k <= 7);
        n_vec++; if (bus.stall !== exp) begin n_err++; $display("FAIL clr_stall k=%0d got %b exp %b", k, bus.stall, exp); end
      end
      if (k == 4) begin
        n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL clr_new_ready got %b exp 1", bus.op_ready); end
        n_vec++; if (bus.xalu_a !== 32'd0) begin n_err++; $display("FAIL clr_a_reset got %h exp 0", bus.xalu_a); end
      end
      if (k == 5) begin
        n_vec++; if (bus.xalu_op !== OP_DIVU) begin n_err++; $display("FAIL clr_new_op got %0d exp 3", bus.xalu_op); end
        n_vec++; if (bus.xalu_a !== 32'd9) begin n_err++; $display("FAIL clr_new_a got %h exp 9", bus.xalu_a); end
      end
    end
    Clr = 1'b0; bus.hilo_read = 1'b0;
  endtask

`ifdef XALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic exp;
    next_cycle();
    bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'd1; bus.op_b = 32'd1;
    bus.xalu_busy = 1'b0; bus.hilo_read = 1'b1;
    @(negedge Clk);
    n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL to_accept got %b exp 1", bus.op_ready); end
    for (int k = 1; k <= 13; k++) begin
      next_cycle();
      bus.op_valid = 1'b0; bus.xalu_busy = 1'b1; Clr = (k == 12);
      @(negedge Clk);
      exp = (k >= 10 && k <= 12);
      n_vec++; if (bus.timeout_err !== exp) begin n_err++; $display("FAIL to_err k=%0d got %b exp %b", k, bus.timeout_err, exp); end
      if (k <= 11) begin
        exp = (k <= 10);
        n_vec++; if (bus.stall !== exp) begin n_err++; $display("FAIL to_stall k=%0d got %b exp %b", k, bus.stall, exp); end
      end
    end
    Clr = 1'b0; bus.xalu_busy = 1'b0; bus.hilo_read = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mult_long();
    test_back_to_back();
    test_intreq();
    test_moves();
    test_clr_wait();
`ifdef XALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
